// File: rtl/mtimer.sv
// ---------------------------------------------------------------------------
// mtimer -- RISC-V machine timer (mtime / mtimecmp) on a 32-bit data bus.
//
// Holds the 64-bit free-running mtime counter, advanced once every PRESCALE
// core clocks, and the 64-bit mtimecmp compare register. Both are visible as
// four 32-bit words. irq_mtimecmp is a registered level (mtime >= mtimecmp).
//
// Bus handshake: sel acts as a valid strobe. The block is always ready, so
// every cycle with sel high is a completed access. Writes land on the next
// rising edge. Reads return the pre-edge register value in rdata one edge
// later, and rdata holds until the next read.
//
// Parameters
//   PRESCALE      core clocks per mtime increment (1..65535)
// Ports
//   clk           core clock, rising edge
//   resetb        asynchronous active-low reset
//   sel           access to this block this cycle
//   we            1 = write, 0 = read (only meaningful with sel)
//   a_word        0 mtime lo, 1 mtime hi, 2 mtimecmp lo, 3 mtimecmp hi
//   wdata         write data
//   be            per-byte write enables
//   rdata         registered read data
//   irq_mtimecmp  registered interrupt level
// ---------------------------------------------------------------------------
module mtimer #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  a_word,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        irq_mtimecmp
);

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    logic [63:0] mtime_q,      mtime_d;
    logic [63:0] mtimecmp_q,   mtimecmp_d;
    logic [15:0] presc_q,      presc_d;
    logic [31:0] rdata_q,      rdata_d;
    logic        irq_q,        irq_d;
    logic [31:0] shadow_q,     shadow_d;
    logic        shadow_vld_q, shadow_vld_d;

    logic tick;
    logic wr;
    logic rd;

    assign tick = (presc_q == PRESC_LAST);
    assign wr   = sel & we;
    assign rd   = sel & ~we;

    // Replace only the enabled bytes of a 32-bit word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  en);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (en[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

    always_comb begin
        mtime_d      = tick ? (mtime_q + 64'd1) : mtime_q;
        mtimecmp_d   = mtimecmp_q;
        presc_d      = tick ? 16'd0 : (presc_q + 16'd1);
        rdata_d      = rdata_q;
        shadow_d     = shadow_q;
        shadow_vld_d = shadow_vld_q;
        // Compare on current register values; the result lags by one edge.
        irq_d        = (mtime_q >= mtimecmp_q);

        if (wr) begin
            case (a_word)
                2'd0: begin
                    // An mtime write overrides the increment and restarts the
                    // prescaler, even when no byte is enabled.
                    mtime_d      = {mtime_q[63:32], merge_bytes(mtime_q[31:0], wdata, be)};
                    presc_d      = 16'd0;
                    shadow_vld_d = 1'b0;
                end
                2'd1: begin
                    mtime_d      = {merge_bytes(mtime_q[63:32], wdata, be), mtime_q[31:0]};
                    presc_d      = 16'd0;
                    shadow_vld_d = 1'b0;
                end
                2'd2: mtimecmp_d = {mtimecmp_q[63:32], merge_bytes(mtimecmp_q[31:0], wdata, be)};
                default: mtimecmp_d = {merge_bytes(mtimecmp_q[63:32], wdata, be), mtimecmp_q[31:0]};
            endcase
        end

        if (rd) begin
            case (a_word)
                2'd0: begin
                    // Snapshot the high half so a following hi read is
                    // coherent with this lo read across a carry.
                    rdata_d      = mtime_q[31:0];
                    shadow_d     = mtime_q[63:32];
                    shadow_vld_d = 1'b1;
                end
                2'd1: begin
                    rdata_d      = shadow_vld_q ? shadow_q : mtime_q[63:32];
                    shadow_vld_d = 1'b0;
                end
                2'd2: rdata_d = mtimecmp_q[31:0];
                default: rdata_d = mtimecmp_q[63:32];
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            mtime_q      <= 64'd0;
            mtimecmp_q   <= 64'hFFFF_FFFF_FFFF_FFFF;
            presc_q      <= 16'd0;
            rdata_q      <= 32'd0;
            irq_q        <= 1'b0;
            shadow_q     <= 32'd0;
            shadow_vld_q <= 1'b0;
        end else begin
            mtime_q      <= mtime_d;
            mtimecmp_q   <= mtimecmp_d;
            presc_q      <= presc_d;
            rdata_q      <= rdata_d;
            irq_q        <= irq_d;
            shadow_q     <= shadow_d;
            shadow_vld_q <= shadow_vld_d;
        end
    end

    assign rdata        = rdata_q;
    assign irq_mtimecmp = irq_q;

endmodule

// File: doc/mtimer.md
# mtimer

Memory-mapped RISC-V machine timer for the rv32i pipeline core. Holds the 64-bit `mtime` counter and 64-bit `mtimecmp` compare register, accessed as four 32-bit words on the core's data bus. Produces the level interrupt `irq_mtimecmp` consumed by the CSR/exception-handling unit, which gates it with `mtie` and edge-detects it.

## Interface
- `PRESCALE`, default 1: core clocks per `mtime` increment; legal range 1..65535.
- `clk`  input  1  core clock; all state updates on the rising edge.
- `resetb`  input  1  reset; asynchronous, active-low.
- `sel`  input  1  bus access to this block this cycle.
- `we`  input  1  write when high, read when low; ignored unless `sel`.
- `a_word`  input  2  word select: 0 = mtime[31:0], 1 = mtime[63:32], 2 = mtimecmp[31:0], 3 = mtimecmp[63:32].
- `wdata`  input  32  write data.
- `be`  input  4  byte enables for writes; `be[i]` covers `wdata[8i+7:8i]`.
- `rdata`  output  32  registered read data.
- `irq_mtimecmp`  output  1  registered level: `mtime >= mtimecmp`.

## Operation
- Reset values: `mtime` = 0, `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF, prescaler count = 0, `rdata` = 0, `irq_mtimecmp` = 0, hi-shadow = 0, shadow-valid = 0.
- Prescaler: counter runs 0..PRESCALE-1. `tick` is asserted when count == PRESCALE-1, and count then returns to 0. With PRESCALE = 1, `tick` is asserted every cycle.
- On `tick`, `mtime` increments by 1 as a 64-bit unsigned value. 2^64-1 wraps to 0 with no flag.
- Write to a_word 0/1:
  - Only the bytes enabled by `be` are replaced in the addressed half; the other half and unenabled bytes are unchanged.
  - The increment is suppressed that cycle, even if `tick` is asserted.
  - The prescaler count resets to 0.
- Write to a_word 2/3: the enabled bytes of `mtimecmp` are replaced. `mtime` is unaffected.
- `be` = 0 on a write: no register changes. For a write to a_word 0/1, the increment is still suppressed and the prescaler is still reset.
- Read (`sel & ~we`):
  - `rdata` ← the addressed word at the next edge.
  - Reading a_word 0 also captures the current `mtime[63:32]` into hi-shadow and sets shadow-valid.
  - Reading a_word 1 returns hi-shadow if shadow-valid, otherwise live `mtime[63:32]`. Either way it clears shadow-valid.
  - Any write to `mtime` clears shadow-valid.
  - Values read are pre-update values (read-old semantics).
- `rdata` holds its last value when there is no read.
- Compare: `irq_mtimecmp` ← (`mtime` >= `mtimecmp`), full 64-bit unsigned, using current register values, every cycle. It stays high until software raises `mtimecmp` or writes `mtime` below it.
- No write to `mtimecmp` is atomic across halves. Software writes lo = FFFF_FFFF first, then hi, then lo. The block does not interlock.

## Timing
- Read latency: 1 cycle. `rdata` is valid on the edge after `sel & ~we`. No wait states; back-to-back accesses are allowed every cycle.
- Write latency: the new value is visible to a read issued on the next cycle.
- `irq_mtimecmp` lags the register state by 1 cycle:
  - `mtime` reaches `mtimecmp` at edge N → `irq_mtimecmp` is high after edge N+1.
  - A `mtimecmp` write at edge N that removes the condition → `irq_mtimecmp` is low after edge N+1.
- Increment cadence: `mtime` advances exactly once per PRESCALE cycles, measured from reset or from the last `mtime` write.
- Simultaneous write to `mtimecmp` and `tick`: both take effect at the same edge.
- Reset asserted mid-operation clears all state immediately, with no clock required. Counting resumes on the first edge after deassertion.

## Test plan
- Reset/count, PRESCALE=1:
  - Release reset, then read a_word 0 after 10 cycles → a value in 9..10 (fixed for the bench).
  - `irq_mtimecmp` = 0 throughout.
  - a_word 2/3 read FFFF_FFFF.
- Prescaler, PRESCALE=4:
  - Write mtime lo = 0 (be = F), then idle 12 cycles → mtime = 3.
  - The increments occur exactly on cycles 4, 8 and 12 after the write.
- Carry and wrap:
  - Write mtime hi = 0, lo = FFFF_FFFF → after 1 tick, hi = 1, lo = 0.
  - Write hi = FFFF_FFFF, lo = FFFF_FFFF → after 1 tick, both halves are 0.
- Shadow read:
  - Set mtime = 0000_0000_FFFF_FFFE, read lo, wait 5 cycles, read hi → hi returns 0 (shadow).
  - An immediate second hi read returns 1 (live).
- Interrupt:
  - mtimecmp = 0000_0000_0000_0020, mtime = 0x1E, PRESCALE=1 → `irq_mtimecmp` rises 1 cycle after mtime = 0x20.
  - Write mtimecmp lo = 0x100 → `irq_mtimecmp` falls 1 cycle later.
- Byte enables and write/tick collision:
  - Write mtimecmp lo = 0xAABBCCDD with be = 4'b0101 onto FFFF_FFFF → reads FFBBFFDD.
  - Write mtime lo = 0x50 on a tick cycle → the next read returns 0x50, not 0x51.
